// File: rtl/icache_refill_writer.sv
// Refill write stage for the L1 icache data RF: buffers refill beats in a small
// FIFO and writes them into consecutive words of the target line.
module icache_refill_writer #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int BEATS_PER_LINE = 4,
  parameter int FIFO_DEPTH     = 2,
  localparam int BW = $clog2(BEATS_PER_LINE),
  localparam int LW = ADDR_WIDTH - BW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  refill_req_i,
  input  logic [LW-1:0]         refill_line_i,
  output logic                  refill_gnt_o,
  input  logic                  rvalid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  rerr_i,
  output logic                  rready_o,
  input  logic                  stall_i,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  busy_o,
  output logic                  refill_done_o,
  output logic                  refill_err_o
);

  // state | meaning
  // IDLE  | waiting for a refill command; grant follows the request
  // FILL  | accepting beats into the FIFO and draining them into the RF
  // DONE  | single-cycle completion pulse with accumulated error status

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [BW:0] BEATS_CNT  = (BW+1)'(BEATS_PER_LINE);
  localparam logic [BW:0] LAST_BEAT  = (BW+1)'(BEATS_PER_LINE - 1);
  localparam logic [BW:0] CNT_ONE    = (BW+1)'(1);
  localparam logic [PW:0] FIFO_FULL  = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] OCC_ONE    = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         line_q;
  logic [BW:0]           in_cnt_q, out_cnt_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW:0]           fifo_cnt_q;
  logic                  fifo_full, fifo_empty;

  logic                  start, push, pop;

  assign fifo_full  = (fifo_cnt_q == FIFO_FULL);
  assign fifo_empty = (fifo_cnt_q == '0);

  always_comb begin
    state_d       = state_q;
    start         = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    refill_gnt_o  = 1'b0;
    rready_o      = 1'b0;
    rf_we_o       = 1'b0;
    rf_waddr_o    = '0;
    rf_wdata_o    = '0;
    busy_o        = 1'b0;
    refill_done_o = 1'b0;
    refill_err_o  = 1'b0;
    // All outputs are forced low while reset is asserted, even mid-line.
    if (rst_n) begin
      unique case (state_q)
        ST_IDLE: begin
          refill_gnt_o = refill_req_i;
          if (refill_req_i) begin
            start   = 1'b1;
            state_d = ST_FILL;
          end
        end
        ST_FILL: begin
          busy_o   = 1'b1;
          rready_o = !fifo_full && (in_cnt_q < BEATS_CNT);
          push     = rvalid_i && rready_o;
          rf_we_o  = !fifo_empty && !stall_i;
          if (rf_we_o) begin
            pop        = 1'b1;
            rf_waddr_o = {line_q, out_cnt_q[BW-1:0]};
            rf_wdata_o = fifo_mem[rd_ptr_q];
            if (out_cnt_q == LAST_BEAT) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          busy_o        = 1'b1;
          refill_done_o = 1'b1;
          refill_err_o  = err_q;
          state_d       = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      line_q     <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        line_q    <= refill_line_i;
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
        err_q     <= 1'b0;
      end else begin
        if (push) begin
          in_cnt_q <= in_cnt_q + CNT_ONE;
          err_q    <= err_q | rerr_i;
        end
        if (pop) out_cnt_q <= out_cnt_q + CNT_ONE;
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + OCC_ONE;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - OCC_ONE;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Beat storage needs no reset; occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= rdata_i;
  end

endmodule
